// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and round-robin helper for the 1-to-4 dispatch stage.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } dispatch_state_t;

    // Advance a channel pointer; the 2-bit width gives the 3->0 wrap for free.
    function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/demux_stall_timer.sv
// Counts consecutive stalled cycles of the held word and flags the cycle on which it must be dropped.
module demux_stall_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear) begin
            stall_cnt_d = '0;
        end else if (enable) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // TIMEOUT of 0 disables dropping; the counter may wrap harmlessly in that case.
    assign expire = (TIMEOUT != 0) && enable && (stall_cnt_q == LAST);

endmodule

// File: rtl/demux1_4_dispatch.sv
// Registered dispatch stage feeding the 1-to-4 demux: holds one word plus select until taken or timed out.
// Optional per-channel transfer counters are built when DEMUX_DISPATCH_STATS_EN is defined.
module demux1_4_dispatch
    import demux_pkg::*;
#(
    parameter int W       = 1,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [SEL_W-1:0]  in_dest,
    input  logic              mode,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_i,
    output logic [SEL_W-1:0]  out_sel,
    output logic              drop_pulse,
    output logic [31:0]       stat_cnt
);

    // Handshake: a word moves when valid and ready are both high in the same cycle;
    // the held word leaves when ch_ready of the selected channel is high while out_valid=1.

    dispatch_state_t  state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic accept;
    logic complete;
    logic expire;

    assign complete = (state_q == SEND) && ch_ready[sel_q];
    assign in_ready = (state_q == IDLE) || complete;
    assign accept   = in_valid && in_ready;

    demux_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable ((state_q == SEND) && !complete),
        .expire (expire)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;

        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: begin
                if (accept) begin
                    state_d = SEND;
                end else if (complete) begin
                    state_d = IDLE;
                end else if (expire) begin
                    state_d = DROP;
                end
            end
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // mode only matters at the moment a word is captured.
        if (accept) begin
            data_d = in_data;
            sel_d  = mode ? rr_ptr_q : in_dest;
            if (mode) begin
                rr_ptr_d = next_rr(rr_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid  = (state_q == SEND);
    assign out_i      = out_valid ? data_q : '0;
    assign out_sel    = sel_q;
    assign drop_pulse = (state_q == DROP);

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [NUM_CH-1:0][7:0] stat_q, stat_d;

    // Saturating counters; a dropped word never reaches complete, so it is not counted.
    always_comb begin
        stat_d = stat_q;
        if (complete && (stat_q[sel_q] != 8'hFF)) begin
            stat_d[sel_q] = stat_q[sel_q] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1_4_dispatch.sv
// Directed bench for demux1_4_dispatch: spec-level model checked every cycle plus literal expectations.
module tb_demux1_4_dispatch;

    localparam int W       = 8;
    localparam int TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_dest;
    logic         mode;
    logic [3:0]   ch_ready;
    logic         out_valid;
    logic [W-1:0] out_i;
    logic [1:0]   out_sel;
    logic         drop_pulse;
    logic [31:0]  stat_cnt;

    int total = 0;
    int bad   = 0;

    demux1_4_dispatch #(
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .mode       (mode),
        .ch_ready   (ch_ready),
        .out_valid  (out_valid),
        .out_i      (out_i),
        .out_sel    (out_sel),
        .drop_pulse (drop_pulse),
        .stat_cnt   (stat_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One slot holding a word, a pending-drop flag, a stall counter and per-channel delivery totals.
    bit         m_hold;
    bit         m_drop;
    logic [7:0] m_data;
    int         m_sel;
    int         m_rr;
    int         m_stall;
    int         m_stat[4];
    bit         chk_en = 1'b0;

    function automatic bit model_ready();
        if (m_drop) return 1'b0;
        if (!m_hold) return 1'b1;
        return ch_ready[m_sel];
    endfunction

    always @(posedge clk) begin
        bit done;
        bit acc;
        if (rst) begin
            m_hold  = 0;
            m_drop  = 0;
            m_data  = '0;
            m_sel   = 0;
            m_rr    = 0;
            m_stall = 0;
            for (int k = 0; k < 4; k++) m_stat[k] = 0;
            chk_en  = 1'b1;
        end else begin
            done = m_hold && ch_ready[m_sel];
            acc  = in_valid && model_ready();
            if (m_drop) begin
                m_drop = 0;
            end else if (m_hold && !done) begin
                m_stall = m_stall + 1;
                if (TIMEOUT != 0 && m_stall == TIMEOUT) begin
                    m_hold = 0;
                    m_drop = 1;
                end
            end
            if (done) begin
                m_hold = 0;
                if (m_stat[m_sel] < 255) m_stat[m_sel] = m_stat[m_sel] + 1;
            end
            if (acc) begin
                m_hold  = 1;
                m_data  = in_data;
                m_stall = 0;
                if (mode) begin
                    m_sel = m_rr;
                    m_rr  = (m_rr + 1) % 4;
                end else begin
                    m_sel = int'(in_dest);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] exp_stat;
        if (chk_en) begin
`ifdef DEMUX_DISPATCH_STATS_EN
            exp_stat = {8'(m_stat[3]), 8'(m_stat[2]), 8'(m_stat[1]), 8'(m_stat[0])};
`else
            exp_stat = 32'd0;
`endif
            check("cyc_out_valid", 32'(out_valid), 32'(m_hold));
            check("cyc_out_i", 32'(out_i), m_hold ? 32'(m_data) : 32'd0);
            if (m_hold) check("cyc_out_sel", 32'(out_sel), 32'(m_sel));
            check("cyc_in_ready", 32'(in_ready), 32'(model_ready()));
            check("cyc_drop_pulse", 32'(drop_pulse), 32'(m_drop));
            check("cyc_stat_cnt", stat_cnt, exp_stat);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = '0;
        in_dest  = 2'd0;
        mode     = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        idle_inputs();
        ch_ready = 4'h0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [1:0] rr_exp [6];
        logic [31:0] stat_exp;
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_i", 32'(out_i), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_drop", 32'(drop_pulse), 32'd0);
        check("rst_stat", stat_cnt, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: explicit destination, latency one cycle, complete the cycle after.
        in_valid = 1'b1; mode = 1'b0; in_dest = 2'd2; in_data = 8'h01; ch_ready = 4'b0100;
        tick();
        in_valid = 1'b0;
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_sel", 32'(out_sel), 32'd2);
        check("t1_data", 32'(out_i), 32'h01);
        tick();
        check("t1_done_valid", 32'(out_valid), 32'd0);
        check("t1_done_data", 32'(out_i), 32'd0);

        // 2: round-robin, six back-to-back words at full throughput.
        mode = 1'b1; ch_ready = 4'hF; in_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            in_data = 8'h10 + 8'(n);
            check("t2_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("t2_sel", 32'(out_sel), 32'(rr_exp[n]));
            check("t2_data", 32'(out_i), 32'h10 + 32'(n));
        end
        idle_inputs();
        tick();
        check("t2_drain", 32'(out_valid), 32'd0);

        // 3: stuck channel 3 -> four SEND cycles, one drop strobe, DROP refuses input, then recovery.
        in_valid = 1'b1; mode = 1'b0; in_dest = 2'd3; in_data = 8'hAA; ch_ready = 4'h0;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check("t3_held", 32'(out_valid), 32'd1);
            check("t3_no_drop", 32'(drop_pulse), 32'd0);
            tick();
        end
        check("t3_drop", 32'(drop_pulse), 32'd1);
        check("t3_drop_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_dest = 2'd0; in_data = 8'h5A; ch_ready = 4'b0001;
        check("t3_drop_ready", 32'(in_ready), 32'd0);
        tick();
        check("t3_idle_drop", 32'(drop_pulse), 32'd0);
        check("t3_idle_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("t3_next_sel", 32'(out_sel), 32'd0);
        check("t3_next_data", 32'(out_i), 32'h5A);
        tick();

        // 4: short stall with unselected channels ready, word held steady then delivered.
        in_valid = 1'b1; mode = 1'b0; in_dest = 2'd1; in_data = 8'hC3; ch_ready = 4'h0;
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_sel_a", 32'(out_sel), 32'd1);
        check("t4_data_a", 32'(out_i), 32'hC3);
        ch_ready = 4'b1101;
        tick();
        check("t4_sel_b", 32'(out_sel), 32'd1);
        check("t4_data_b", 32'(out_i), 32'hC3);
        check("t4_no_drop", 32'(drop_pulse), 32'd0);
        ch_ready = 4'b0010;
        tick();
        check("t4_delivered", 32'(out_valid), 32'd0);
        check("t4_no_drop_end", 32'(drop_pulse), 32'd0);

        // 5: reset while a word is held; rr_ptr returns to 0 (rr_ptr is 2 here).
        in_valid = 1'b1; mode = 1'b1; in_data = 8'h77; ch_ready = 4'h0;
        tick();
        in_valid = 1'b0;
        check("t5_held_sel", 32'(out_sel), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data", 32'(out_i), 32'd0);
        check("t5_drop", 32'(drop_pulse), 32'd0);
        in_valid = 1'b1; mode = 1'b1; in_data = 8'h33; ch_ready = 4'h1;
        tick();
        in_valid = 1'b0;
        check("t5_rr_restart", 32'(out_sel), 32'd0);
        tick();

        // 6: 300 completes to channel 1 from a clean reset.
        do_reset(1);
        in_valid = 1'b1; mode = 1'b0; in_dest = 2'd1; ch_ready = 4'b0010;
        for (int n = 0; n < 300; n++) begin
            in_data = 8'($urandom_range(0, 255));
            tick();
        end
        idle_inputs();
        tick();
`ifdef DEMUX_DISPATCH_STATS_EN
        stat_exp = 32'h0000_FF00;
`else
        stat_exp = 32'h0;
`endif
        check("t6_stat", stat_cnt, stat_exp);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
